// File: rtl/downstream_update_ctrl.sv
// Multi-channel downstream update controller: per-channel IDLE/PENDING/UPDATE_MEM FSMs sharing one
// round-robin arbitrated memory write port. Optional per-channel timeout via `DOWNSTREAM_TIMEOUT_EN.
module downstream_update_ctrl #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        ack,
  input  logic [CHANNELS-1:0]        memwr,
  input  logic [CHANNELS*ADDR_W-1:0] req_addr,
  input  logic [CHANNELS*DATA_W-1:0] req_data,
  input  logic [CHANNELS-1:0]        err_clr,
  input  logic                       mem_ready,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [CHANNELS-1:0]        busy,
  output logic [CHANNELS-1:0]        err,
  output logic [CNT_W-1:0]           done_count
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SUM_W = $clog2(CHANNELS + 1);
  localparam logic [PTR_W:0]   CH_N     = (PTR_W+1)'(CHANNELS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(CHANNELS - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_PEND = 4'b0010,
    S_UPD  = 4'b0100,
    S_ERR  = 4'b1000
  } state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [ADDR_W-1:0]   addr_q  [CHANNELS];
  logic [DATA_W-1:0]   data_q  [CHANNELS];
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W:0]      arb_sum;
  logic                gnt_vld;
  logic [PTR_W-1:0]    gnt_idx;
  logic [CHANNELS-1:0] pend, cmpl;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [CNT_W-1:0]    done_q, done_d;
  logic [SUM_W-1:0]    cmpl_sum;
  logic [CNT_W:0]      done_sum;

`ifdef DOWNSTREAM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q [CHANNELS];

  // Counter sits at zero outside UPDATE_MEM, so it is clear on every entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst || state_q[i] != S_UPD) tmo_q[i] <= '0;
      else                            tmo_q[i] <= tmo_q[i] + 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = ^err_clr;
`endif

  always_comb begin
    pend = '0;
    busy = '0;
    err  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pend[i] = (state_q[i] == S_PEND);
      busy[i] = pend[i] || (state_q[i] == S_UPD);
`ifdef DOWNSTREAM_TIMEOUT_EN
      err[i]  = (state_q[i] == S_ERR);
`endif
    end
  end

  // Round-robin: first PENDING channel at or after the pointer, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    arb_sum = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      arb_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (arb_sum >= CH_N) arb_sum = arb_sum - CH_N;
      if (mem_ready && !gnt_vld && pend[arb_sum[PTR_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = arb_sum[PTR_W-1:0];
      end
    end
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    cmpl = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE: if (ack[i]) state_d[i] = S_PEND;
        S_PEND: if (gnt_vld && gnt_idx == PTR_W'(i)) state_d[i] = S_UPD;
        S_UPD: begin
          if (memwr[i]) begin
            state_d[i] = S_IDLE;
            cmpl[i]    = 1'b1;
          end
`ifdef DOWNSTREAM_TIMEOUT_EN
          else if (tmo_q[i] == TMO_LAST) state_d[i] = S_ERR;
`endif
        end
`ifdef DOWNSTREAM_TIMEOUT_EN
        S_ERR:  if (err_clr[i]) state_d[i] = S_IDLE;
`endif
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Saturating add: the carry bit flags that the true sum exceeds the counter range.
  always_comb begin
    cmpl_sum = '0;
    for (int i = 0; i < CHANNELS; i++) cmpl_sum = cmpl_sum + SUM_W'(cmpl[i]);
    done_sum = {1'b0, done_q} + (CNT_W+1)'(cmpl_sum);
    done_d   = done_sum[CNT_W] ? '1 : done_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= S_IDLE;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
      end
      ptr_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        if (state_q[i] == S_IDLE && ack[i]) begin
          addr_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
          data_q[i] <= req_data[i*DATA_W +: DATA_W];
        end
      end
      ptr_q    <= ptr_d;
      mem_we_q <= gnt_vld;
      if (gnt_vld) begin
        mem_addr_q  <= addr_q[gnt_idx];
        mem_wdata_q <= data_q[gnt_idx];
      end
      done_q <= done_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign done_count = done_q;

endmodule

// File: doc/downstream_update_ctrl.md
Name: downstream_update_ctrl

Overview:
Multi-channel successor to the single-channel downstream update FSM. Each of CHANNELS channels runs its own IDLE -> update -> IDLE sequence, triggered by ack and closed by memwr. Channels capture an address/data pair on ack and share one memory write port through a round-robin arbiter. Sits between the cache-side acknowledge logic and the backing-memory write interface.

Parameters:
CHANNELS, 4, number of independent downstream channels (1..16)
ADDR_W, 8, memory address width
DATA_W, 32, memory data width
TIMEOUT, 16, cycles allowed in UPDATE_MEM before error (>=1; used only with the optional feature)
CNT_W, 16, width of the completed-update counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
ack  in  CHANNELS  per-channel update request; sampled only in IDLE
memwr  in  CHANNELS  per-channel write-confirm; sampled only in UPDATE_MEM
req_addr  in  CHANNELS*ADDR_W  per-channel address, channel i at bits [i*ADDR_W +: ADDR_W]
req_data  in  CHANNELS*DATA_W  per-channel data, same packing
err_clr  in  CHANNELS  per-channel error clear
mem_ready  in  1  memory port can accept a write this cycle
mem_we  out  1  registered one-cycle write strobe
mem_addr  out  ADDR_W  registered write address
mem_wdata  out  DATA_W  registered write data
busy  out  CHANNELS  1 when the channel is in PENDING or UPDATE_MEM (successor of legacy "out")
err  out  CHANNELS  1 when the channel is in ERROR
done_count  out  CNT_W  completed updates, all channels

Behaviour:
- Reset (rst=1 at clk edge): all channels go to IDLE. Arbiter pointer = 0. mem_we=0, mem_addr=0, mem_wdata=0, busy=0, err=0, done_count=0. Reset overrides all other inputs. Reset mid-operation discards pending captures, with no write issued.
- Per-channel states: IDLE, PENDING, UPDATE_MEM, ERROR. The encoding is one-hot.
- IDLE: if ack[i]=1, capture the channel's req_addr/req_data slice and go to PENDING next cycle. memwr[i] is ignored in IDLE, including when it is high at the same time as ack.
- PENDING: hold the captured values and request the arbiter.
  - Arbiter runs only when mem_ready=1. It grants the first PENDING channel at or after the pointer, wrapping modulo CHANNELS. At most one grant per cycle.
  - On a grant, the next edge sets mem_we=1 with the captured addr/data, the channel moves to UPDATE_MEM, and the pointer becomes (granted+1) mod CHANNELS.
  - mem_we is high for exactly one cycle per grant. It is 0 in any cycle without a grant, and mem_addr/mem_wdata hold their last values.
- UPDATE_MEM: if memwr[i]=1, go to IDLE next cycle and add 1 to done_count.
  - ack[i] is ignored in UPDATE_MEM. A new ack is taken only once the channel is back in IDLE.
- done_count: if several channels complete in the same cycle, add the number of completing channels. Saturate at 2^CNT_W-1; never wrap.
- Latency:
  - ack to busy: 1 cycle.
  - ack to mem_we: 2 cycles minimum (uncontended, mem_ready=1).
  - memwr to busy low: 1 cycle.
- ERROR: exists only with the optional feature. err_clr[i]=1 goes to IDLE next cycle. Without a clear, ERROR is sticky.

Optional Feature:
DOWNSTREAM_TIMEOUT_EN
- Defined:
  - Each channel has a counter, clog2(TIMEOUT+1) bits wide. It clears on entry to UPDATE_MEM and increments every cycle in UPDATE_MEM.
  - When the count reaches TIMEOUT with memwr[i]=0, the channel goes to ERROR. done_count does not increment.
  - If memwr[i]=1 arrives in the same cycle as the timeout, memwr wins and the channel goes to IDLE.
  - err[i]=1 while in ERROR.
- Undefined: no counters, no ERROR state. UPDATE_MEM waits indefinitely for memwr. err is tied to 0 and err_clr is ignored.

Test Plan:
- Single channel: ack[0] pulse with addr=0x12, data=0xDEADBEEF, mem_ready=1 -> busy[0]=1 at +1, mem_we=1 with 0x12/0xDEADBEEF at +2 for one cycle, memwr[0] then busy[0]=0 next cycle, done_count=1.
- Contention: ack on channels 0-3 in the same cycle -> mem_we pulses on 4 consecutive cycles in order 0,1,2,3. A second round started with pointer=2 grants in order 2,3,0,1.
- Backpressure: mem_ready=0 for 5 cycles with channel 1 PENDING -> mem_we stays 0 and busy[1] stays 1. Write issued 1 cycle after mem_ready rises.
- Simultaneous events:
  - ack and memwr high together in IDLE -> channel enters PENDING.
  - Two channels' memwr in the same cycle -> done_count +2.
  - Counter preloaded near max -> done_count saturates at 0xFFFF.
- Timeout (DOWNSTREAM_TIMEOUT_EN, TIMEOUT=16):
  - No memwr for 16 cycles -> err[2]=1, done_count unchanged. err_clr -> IDLE next cycle.
  - memwr on cycle 16 -> IDLE, no error.
- Reset mid-operation: rst during PENDING and UPDATE_MEM -> all outputs 0 next cycle, no mem_we afterward.
